tmds_word_aligner: RTL and testbench



---
 rtl/tmds_word_aligner.sv | 173 +++++++++++++++++
 tb/tb_tmds_word_aligner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_word_aligner.sv
// HDMI RX fabric word aligner: per-channel barrel shift onto the TMDS word boundary,
// found by hunting for control tokens, with lock acquisition and loss-of-lock monitoring.

module tmds_word_aligner_ch #(
  parameter int SEARCH_WINDOW = 256,
  parameter int LOCK_TOKENS   = 4,
  parameter int LOSS_WINDOW   = 2048,
  parameter int CW            = $clog2(LOSS_WINDOW) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld,
  input  logic [9:0] cur,
  output logic [9:0] aligned_q,
  output logic [3:0] off_q,
  output logic       locked,
  output logic       lock_lost_q
);
  typedef enum logic [1:0] {S_SEARCH, S_CONFIRM, S_LOCKED} state_t;

  localparam logic [CW-1:0] SW_C = CW'(SEARCH_WINDOW);
  localparam logic [CW-1:0] LW_C = CW'(LOSS_WINDOW);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [3:0]    LT_C = 4'(LOCK_TOKENS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    tok_q, tok_d, tok_inc, off_d, off_slip;
  logic [9:0]    prev_q, aligned;
  logic [19:0]   cat;
  logic          tok, lost_d;

  // Previous word sits in the low half, so offset k starts the word at prev bit k.
  assign cat      = {cur, prev_q};
  assign aligned  = cat[{1'b0, off_q} +: 10];
  assign tok      = (aligned == 10'h354) || (aligned == 10'h0AB) ||
                    (aligned == 10'h154) || (aligned == 10'h2AB);
  assign off_slip = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
  assign cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
  assign tok_inc  = (tok_q == 4'hF) ? tok_q : tok_q + 4'd1;
  assign locked   = (state_q == S_LOCKED);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tok_d   = tok_q;
    off_d   = off_q;
    lost_d  = 1'b0;
    if (vld) begin
      // A token always beats a window expiring on the same word.
      unique case (state_q)
        S_SEARCH: begin
          if (tok) begin
            tok_d   = 4'd1;
            cnt_d   = '0;
            state_d = (LOCK_TOKENS == 1) ? S_LOCKED : S_CONFIRM;
          end else if (cnt_inc >= SW_C) begin
            off_d = off_slip;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_CONFIRM: begin
          if (tok) begin
            tok_d = tok_inc;
            cnt_d = '0;
            if (tok_inc >= LT_C) state_d = S_LOCKED;
          end else if (cnt_inc >= SW_C) begin
            off_d   = off_slip;
            cnt_d   = '0;
            tok_d   = '0;
            state_d = S_SEARCH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_LOCKED: begin
          if (tok) begin
            cnt_d = '0;
          end else if (cnt_inc >= LW_C) begin
            lost_d  = 1'b1;
            off_d   = off_slip;
            cnt_d   = '0;
            tok_d   = '0;
            state_d = S_SEARCH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SEARCH;
      cnt_q       <= '0;
      tok_q       <= '0;
      off_q       <= '0;
      prev_q      <= '0;
      aligned_q   <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tok_q       <= tok_d;
      off_q       <= off_d;
      lock_lost_q <= lost_d;
      if (vld) begin
        prev_q    <= cur;
        aligned_q <= aligned;
      end
    end
  end
endmodule

module tmds_word_aligner #(
  parameter int NUM_CH        = 3,
  parameter int SEARCH_WINDOW = 256,
  parameter int LOCK_TOKENS   = 4,
  parameter int LOSS_WINDOW   = 2048
) (
  input  logic                   i_pixclk,
  input  logic                   i_rst,
  input  logic                   i_raw_valid,
  input  logic [NUM_CH*10-1:0]   i_raw_data,
  output logic                   o_valid,
  output logic [NUM_CH*10-1:0]   o_aligned_data,
  output logic [NUM_CH*4-1:0]    o_offset,
  output logic [NUM_CH-1:0]      o_locked,
  output logic                   o_all_locked,
  output logic [NUM_CH-1:0]      o_lock_lost
);
  localparam int STAGES = 1;
  localparam int CW     = $clog2(LOSS_WINDOW) + 1;

  logic [STAGES:0]          vld_pipe;
  logic [NUM_CH-1:0][9:0]   raw, aligned;
  logic [NUM_CH-1:0][3:0]   off;

  assign raw         = i_raw_data;
  assign vld_pipe[0] = i_raw_valid;

  always_ff @(posedge i_pixclk) begin
    if (i_rst) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tmds_word_aligner_ch #(
      .SEARCH_WINDOW (SEARCH_WINDOW),
      .LOCK_TOKENS   (LOCK_TOKENS),
      .LOSS_WINDOW   (LOSS_WINDOW),
      .CW            (CW)
    ) u_ch (
      .clk         (i_pixclk),
      .rst         (i_rst),
      .vld         (i_raw_valid),
      .cur         (raw[c]),
      .aligned_q   (aligned[c]),
      .off_q       (off[c]),
      .locked      (o_locked[c]),
      .lock_lost_q (o_lock_lost[c])
    );
  end

  assign o_valid        = vld_pipe[STAGES];
  assign o_aligned_data = aligned;
  assign o_offset       = off;
  assign o_all_locked   = &o_locked;
endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: serial streams are built per channel at a
// chosen true bit offset and lock/offset/loss behaviour is checked at fixed word counts.

module tb_tmds_word_aligner;
  localparam int NUM_CH = 3;

  logic        i_pixclk = 1'b0;
  logic        i_rst;
  logic        i_raw_valid;
  logic [29:0] i_raw_data;
  logic        o_valid;
  logic [29:0] o_aligned_data;
  logic [11:0] o_offset;
  logic [2:0]  o_locked;
  logic        o_all_locked;
  logic [2:0]  o_lock_lost;

  int checks = 0;
  int errors = 0;
  logic [9:0] pt [3];
  int         kk [3];

  tmds_word_aligner #(
    .NUM_CH        (NUM_CH),
    .SEARCH_WINDOW (16),
    .LOCK_TOKENS   (4),
    .LOSS_WINDOW   (32)
  ) dut (
    .i_pixclk       (i_pixclk),
    .i_rst          (i_rst),
    .i_raw_valid    (i_raw_valid),
    .i_raw_data     (i_raw_data),
    .o_valid        (o_valid),
    .o_aligned_data (o_aligned_data),
    .o_offset       (o_offset),
    .o_locked       (o_locked),
    .o_all_locked   (o_all_locked),
    .o_lock_lost    (o_lock_lost)
  );

  always #5 i_pixclk = ~i_pixclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_pixclk);
    #1;
  endtask

  // Raw deserializer word when the transmitted word boundary sits at bit offset k.
  function automatic logic [9:0] mk_raw(input logic [9:0] t, input logic [9:0] p, input int k);
    logic [19:0] c;
    c = {t, p} >> (10 - k);
    return c[9:0];
  endfunction

  task automatic send_t(input logic [9:0] t0, input logic [9:0] t1, input logic [9:0] t2);
    logic [9:0] t [3];
    t[0] = t0; t[1] = t1; t[2] = t2;
    for (int c = 0; c < NUM_CH; c++) begin
      i_raw_data[c*10 +: 10] = mk_raw(t[c], pt[c], kk[c]);
      pt[c] = t[c];
    end
    i_raw_valid = 1'b1;
    tick();
  endtask

  task automatic do_reset(input int n);
    i_raw_valid = 1'b0;
    i_rst = 1'b1;
    repeat (n) tick();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_raw_valid = 1'b1;
    i_raw_data = {3{10'h354}};
    for (int c = 0; c < NUM_CH; c++) begin kk[c] = 0; pt[c] = '0; end

    // reset held with valid data present
    repeat (4) tick();
    chk("rst_valid",  o_valid, 0);
    chk("rst_data",   o_aligned_data, 0);
    chk("rst_off",    o_offset, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_all",    o_all_locked, 0);
    chk("rst_lost",   o_lock_lost, 0);
    i_raw_valid = 1'b0;
    i_rst = 1'b0;

    // aligned lock on channel 0; first word only sees the cleared prev register
    repeat (3) send_t(10'h354, 10'h000, 10'h000);
    chk("al_early_lock", o_locked[0], 0);
    repeat (2) send_t(10'h354, 10'h000, 10'h000);
    chk("al_lock",  o_locked[0], 1);
    chk("al_off",   o_offset[3:0], 0);
    chk("al_data",  o_aligned_data[9:0], 10'h354);
    chk("al_valid", o_valid, 1);

    // misaligned at offset 3: 0x0AB every 4th word, 0x1F0 otherwise
    do_reset(1);
    kk[0] = 3; pt[0] = 10'h1F0;
    for (int m = 0; m <= 60; m++) begin
      send_t((m % 4 == 3) ? 10'h0AB : 10'h1F0, 10'h000, 10'h000);
      if (m == 14) chk("mis_off0", o_offset[3:0], 0);
      if (m == 15) chk("mis_off1", o_offset[3:0], 1);
      if (m == 31) chk("mis_off2", o_offset[3:0], 2);
      if (m == 47) chk("mis_off3", o_offset[3:0], 3);
      if (m == 59) chk("mis_prelock", o_locked[0], 0);
      if (m == 60) begin
        chk("mis_lock", o_locked[0], 1);
        chk("mis_offl", o_offset[3:0], 3);
        chk("mis_data", o_aligned_data[9:0], 10'h0AB);
      end
    end

    // loss of lock: 32 token-free words
    for (int m = 61; m <= 93; m++) begin
      send_t(10'h1F0, 10'h000, 10'h000);
      if (m == 91) begin
        chk("loss_hold_lock", o_locked[0], 1);
        chk("loss_no_pulse",  o_lock_lost[0], 0);
      end
      if (m == 92) begin
        chk("loss_pulse",  o_lock_lost[0], 1);
        chk("loss_locked", o_locked[0], 0);
        chk("loss_off",    o_offset[3:0], 4);
      end
      if (m == 93) chk("loss_pulse_end", o_lock_lost[0], 0);
    end

    // offset wrap with valid toggling every other cycle
    do_reset(1);
    for (int c = 0; c < NUM_CH; c++) begin kk[c] = 0; pt[c] = '0; end
    for (int i = 1; i <= 160; i++) begin
      send_t(10'h000, 10'h000, 10'h000);
      if (i == 1)   chk("gate_valid_hi", o_valid, 1);
      if (i == 15)  chk("gate_off15", o_offset, 12'h000);
      if (i == 16)  chk("gate_off16", o_offset, 12'h111);
      if (i == 144) chk("wrap_off9", o_offset, 12'h999);
      if (i == 160) chk("wrap_off0", o_offset, 12'h000);
      i_raw_valid = 1'b0;
      tick();
      if (i == 1)  chk("gate_valid_lo", o_valid, 0);
      if (i == 16) chk("gate_hold_off", o_offset, 12'h111);
    end

    // three channels at true offsets 0 / 5 / 9
    do_reset(1);
    kk[0] = 0; kk[1] = 5; kk[2] = 9;
    for (int c = 0; c < NUM_CH; c++) pt[c] = 10'h354;
    for (int n = 0; n <= 147; n++) begin
      send_t(10'h354, 10'h354, 10'h354);
      if (n == 82) chk("mc_lock_a", o_locked, 3'b001);
      if (n == 83) begin
        chk("mc_lock_b", o_locked, 3'b011);
        chk("mc_all_b",  o_all_locked, 0);
      end
      if (n == 146) chk("mc_all_c", o_all_locked, 0);
      if (n == 147) begin
        chk("mc_lock_d", o_locked, 3'b111);
        chk("mc_all_d",  o_all_locked, 1);
        chk("mc_off_d",  o_offset, 12'h950);
        chk("mc_data_d", o_aligned_data, {10'h354, 10'h354, 10'h354});
      end
    end

    // reset while locked
    i_rst = 1'b1;
    i_raw_valid = 1'b1;
    tick();
    chk("mr_locked", o_locked, 0);
    chk("mr_all",    o_all_locked, 0);
    chk("mr_off",    o_offset, 0);
    chk("mr_data",   o_aligned_data, 0);
    chk("mr_valid",  o_valid, 0);
    i_rst = 1'b0;
    i_raw_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
